ines_stream_loader: RTL

Receiving end of the iNES byte-stream feed. Consumes the `downloading` / `indata` / `indata_clk` strobe stream, validates and parses the 16-byte iNES header, and optionally skips a 512-byte trainer. PRG and CHR payload bytes go through a small FIFO to a byte-wide memory write port with backpressure. Publishes cartridge configuration (mapper, mirroring, sizes) to the mapper/PPU logic and reports done/error.

---
 rtl/ines_pkg.sv | 51 +++++
 rtl/ines_byte_fifo.sv | 54 +++++
 rtl/ines_stream_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ines_pkg.sv
// Shared types and constants for the iNES stream loader.
// INES_NES2_EN widens bank counts and the byte counter for NES 2.0 headers.
package ines_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StTrainer,
    StPrg,
    StChr,
    StDrain,
    StDone,
    StError
  } load_state_e;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrMagic = 2'd1;
  localparam logic [1:0] ErrSize  = 2'd2;
  localparam logic [1:0] ErrTrunc = 2'd3;

  localparam logic [31:0] INES_MAGIC = 32'h1A53454E;

  localparam int unsigned HdrPrgBanks = 4;
  localparam int unsigned HdrChrBanks = 5;
  localparam int unsigned HdrFlags6   = 6;
  localparam int unsigned HdrFlags7   = 7;
  localparam int unsigned HdrLast     = 15;

  localparam int unsigned PRG_BANK_BYTES = 16384;
  localparam int unsigned CHR_BANK_BYTES = 8192;
  localparam int unsigned TRAINER_BYTES  = 512;

`ifdef INES_NES2_EN
  localparam int unsigned HdrSizeMsb = 9;
  localparam int unsigned BankW      = 12;
  localparam int unsigned CntW       = 26;
  localparam int unsigned HdrKeep    = 10;
`else
  localparam int unsigned BankW      = 8;
  localparam int unsigned CntW       = 23;
  localparam int unsigned HdrKeep    = 8;
`endif
  localparam int unsigned HdrIdxW = $clog2(HdrKeep);

  // Index of the final byte of a section that is banks*unit_bytes long.
  function automatic logic [CntW-1:0] bank_last(input logic [BankW-1:0] banks,
                                                input int unsigned     unit_bytes);
    return CntW'(banks) * CntW'(unit_bytes) - CntW'(1);
  endfunction

endpackage

// File: rtl/ines_byte_fifo.sv
// Synchronous {addr, data} FIFO between the stream parser and the memory write port.
// Head entry is read straight from storage so a pop exposes the next entry with no bubble.
module ines_byte_fifo #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [7:0]        push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [7:0]        head_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W+7:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push, do_pop;

  assign full    = count_q == (PtrW + 1)'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr, push_data};
  end

  assign {head_addr, head_data} = mem_q[rd_ptr_q];

endmodule

// File: rtl/ines_stream_loader.sv
// iNES image loader: checks the header, skips the trainer and streams PRG/CHR bytes to memory.
// Define INES_NES2_EN to honour NES 2.0 12-bit bank counts.
module ines_stream_loader
  import ines_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] CHR_BASE   = 22'h200000,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              downloading,
  input  logic [7:0]        indata,
  input  logic              indata_clk,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic [7:0]        mapper,
  output logic [1:0]        mirroring,
  output logic              has_battery,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [CntW-1:0] TrainerLast = CntW'(TRAINER_BYTES - 1);

  load_state_e       state_q;
  logic              dl_q;
  logic [CntW-1:0]   cnt_q;
  logic [7:0]        hdr_q [HdrKeep];
  logic [BankW-1:0]  prg_cnt_q, chr_cnt_q;

  logic              byte_ok, dl_rise, loading, payload, trunc, overflow;
  logic              push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] push_addr;
  logic              magic_ok, exp_form, size_bad;
  logic [BankW-1:0]  hdr_prg, hdr_chr;
  logic [CntW-1:0]   prg_last, chr_last;

  assign byte_ok  = indata_clk && downloading;
  assign dl_rise  = downloading && !dl_q;
  assign loading  = state_q inside {StHeader, StTrainer, StPrg, StChr};
  assign payload  = state_q inside {StPrg, StChr};
  assign trunc    = loading && !downloading;
  assign overflow = payload && byte_ok && fifo_full;
  assign push     = payload && byte_ok && !fifo_full;
  assign pop      = mem_write && mem_ready;
  // Abort on the same edge the error is seen so mem_write drops on the next cycle.
  assign flush    = dl_rise || trunc || overflow;

  assign push_addr = (state_q == StChr) ? CHR_BASE + ADDR_W'(cnt_q) : ADDR_W'(cnt_q);

  assign magic_ok = {hdr_q[3], hdr_q[2], hdr_q[1], hdr_q[0]} == INES_MAGIC;

`ifdef INES_NES2_EN
  logic nes2;
  assign nes2     = hdr_q[HdrFlags7][3:2] == 2'b10;
  assign hdr_prg  = nes2 ? {hdr_q[HdrSizeMsb][3:0], hdr_q[HdrPrgBanks]}
                         : {4'h0, hdr_q[HdrPrgBanks]};
  assign hdr_chr  = nes2 ? {hdr_q[HdrSizeMsb][7:4], hdr_q[HdrChrBanks]}
                         : {4'h0, hdr_q[HdrChrBanks]};
  assign exp_form = nes2 && (hdr_q[HdrSizeMsb][3:0] == 4'hF || hdr_q[HdrSizeMsb][7:4] == 4'hF);
`else
  assign hdr_prg  = hdr_q[HdrPrgBanks];
  assign hdr_chr  = hdr_q[HdrChrBanks];
  assign exp_form = 1'b0;
`endif

  assign size_bad = exp_form || (hdr_prg == '0);
  assign prg_last = bank_last(prg_cnt_q, PRG_BANK_BYTES);
  assign chr_last = bank_last(chr_cnt_q, CHR_BANK_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      // Treat downloading as already high so a reset mid-load waits for a fresh rising edge.
      dl_q        <= 1'b1;
      cnt_q       <= '0;
      for (int i = 0; i < int'(HdrKeep); i++) hdr_q[i] <= '0;
      prg_cnt_q   <= '0;
      chr_cnt_q   <= '0;
      prg_banks   <= '0;
      chr_banks   <= '0;
      mapper      <= '0;
      mirroring   <= '0;
      has_battery <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ErrNone;
    end else begin
      dl_q <= downloading;
      if (dl_rise) begin
        state_q  <= StHeader;
        cnt_q    <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
        err_code <= ErrNone;
      end else if (trunc || overflow) begin
        state_q  <= StError;
        error    <= 1'b1;
        err_code <= ErrTrunc;
      end else begin
        unique case (state_q)
          StHeader: begin
            if (byte_ok) begin
              cnt_q <= cnt_q + CntW'(1);
              if (cnt_q < CntW'(HdrKeep)) hdr_q[cnt_q[HdrIdxW-1:0]] <= indata;
              if (cnt_q == CntW'(HdrLast)) begin
                cnt_q <= '0;
                if (!magic_ok) begin
                  state_q  <= StError;
                  error    <= 1'b1;
                  err_code <= ErrMagic;
                end else if (size_bad) begin
                  state_q  <= StError;
                  error    <= 1'b1;
                  err_code <= ErrSize;
                end else begin
                  prg_cnt_q   <= hdr_prg;
                  chr_cnt_q   <= hdr_chr;
                  prg_banks   <= hdr_q[HdrPrgBanks];
                  chr_banks   <= hdr_q[HdrChrBanks];
                  mapper      <= {hdr_q[HdrFlags7][7:4], hdr_q[HdrFlags6][7:4]};
                  mirroring   <= {hdr_q[HdrFlags6][3], hdr_q[HdrFlags6][0]};
                  has_battery <= hdr_q[HdrFlags6][1];
                  state_q     <= hdr_q[HdrFlags6][2] ? StTrainer : StPrg;
                end
              end
            end
          end
          StTrainer: begin
            if (byte_ok) begin
              if (cnt_q == TrainerLast) begin
                cnt_q   <= '0;
                state_q <= StPrg;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          StPrg: begin
            if (push) begin
              if (cnt_q == prg_last) begin
                cnt_q   <= '0;
                state_q <= (chr_cnt_q == '0) ? StDrain : StChr;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          StChr: begin
            if (push) begin
              if (cnt_q == chr_last) begin
                cnt_q   <= '0;
                state_q <= StDrain;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          StDrain: begin
            if (fifo_empty) begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  ines_byte_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_addr (push_addr),
    .push_data (indata),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (mem_addr),
    .head_data (mem_data)
  );

  assign mem_write = !fifo_empty;

endmodule
